// File: rtl/regfile_scoreboard.sv
// Register file with two registered read ports and a write-first bypass.
// A per-entry busy scoreboard tracks dispatched-but-not-written-back destinations.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issueRd,
  output logic [DATA_W-1:0] rsOut,
  output logic [DATA_W-1:0] rtOut,
  output logic              rsBusy,
  output logic              rtBusy,
  output logic [ADDR_W:0]   pendCount
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  next_busy;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [ADDR_W:0]   next_pend;
  logic              wr_en;

  assign wr_en = wrt && !(ZR && rd == '0);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    next_busy = busy;
    if (wrt)
      next_busy[rd] = 1'b0;
    // Issue is applied after the clear so a same-cycle dispatch wins over write-back.
    if (issue && !(ZR && issueRd == '0))
      next_busy[issueRd] = 1'b1;

    next_pend = '0;
    for (int i = 0; i < DEPTH; i++)
      next_pend = next_pend + {{ADDR_W{1'b0}}, next_busy[i]};
  end

  always_comb begin
    rs_data = regs[rs];
    if (wr_en && rd == rs)
      rs_data = dataIn;
    if (ZR && rs == '0)
      rs_data = '0;

    rt_data = regs[rt];
    if (wr_en && rd == rt)
      rt_data = dataIn;
    if (ZR && rt == '0)
      rt_data = '0;
  end

  // NOTE: the storage array is reset here because reset must clear every entry; that
  // costs flops instead of RAM, which is the intended trade for this small file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs      <= '{default: '0};
      busy      <= '0;
      rsOut     <= '0;
      rtOut     <= '0;
      rsBusy    <= 1'b0;
      rtBusy    <= 1'b0;
      pendCount <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
      if (wr_en)
        regs[rd] <= dataIn;
      busy      <= next_busy;
      rsOut     <= rs_data;
      rtOut     <= rt_data;
      rsBusy    <= next_busy[rs];
      rtBusy    <= next_busy[rt];
      pendCount <= next_pend;
    end
  end

endmodule
